// File: rtl/lector_fifos_azules_pkg.sv
// ============================================================================
// Module   : lector_fifos_azules_pkg
// Brief    : Shared widths, port count, counter-select codes and FSM states
//            for the blue-FIFO read merger.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lector_fifos_azules_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int CNT_WIDTH  = 5;
  localparam int NUM_PORTS  = 4;

  localparam logic [2:0] IDX_TOTAL = 3'd4;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/lector_fifos_azules_arbitro.sv
// ============================================================================
// Module   : arbitro_rr4
// Brief    : 4-way round-robin grant; the pointer moves past each winner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr4
  import lector_fifos_azules_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant
);

  logic [1:0] r_ptr;
  logic [1:0] w_cand;
  logic [1:0] w_win;
  logic       w_any;

  // Scanning from the far end downwards leaves the nearest requester at or
  // after the pointer as the winner.
  always_comb begin
    w_cand = r_ptr;
    w_win  = r_ptr;
    w_any  = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_cand = r_ptr + 2'(k);
      if (req[w_cand]) begin
        w_win = w_cand;
        w_any = 1'b1;
      end
    end
  end

  assign grant = (en && w_any) ? (4'b0001 << w_win) : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 2'd0;
    end else if (clear) begin
      r_ptr <= 2'd0;
    end else if (en && w_any) begin
      r_ptr <= w_win + 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lector_fifos_azules.sv
// ============================================================================
// Module   : lector_fifos_azules
// Brief    : Round-robin merger of the four blue FIFOs into one word stream,
//            with per-port and total forwarded-word counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lector_fifos_azules #(
  parameter int DATA_WIDTH = lector_fifos_azules_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = lector_fifos_azules_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Enable,
  input  logic                  init,
  input  logic [DATA_WIDTH-1:0] data_in_p0,
  input  logic [DATA_WIDTH-1:0] data_in_p1,
  input  logic [DATA_WIDTH-1:0] data_in_p2,
  input  logic [DATA_WIDTH-1:0] data_in_p3,
  input  logic [3:0]            empty_azules,
  input  logic                  almost_full_out,
  input  logic                  req,
  input  logic [2:0]            idx,
  output logic [3:0]            pop_fifo_azules,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [CNT_WIDTH-1:0]  salida_contador,
  output logic                  valid_contador,
  output logic                  idle
);

  import lector_fifos_azules_pkg::*;

  state_t                r_state;
  state_t                w_next;
  logic                  r_idle;
  logic                  w_pop_en;
  logic [3:0]            w_grant;
  logic [1:0]            w_grant_idx;
  logic                  r_v1;
  logic [1:0]            r_tag1;
  logic                  r_v2;
  logic [1:0]            r_tag2;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_sel;
  logic [CNT_WIDTH-1:0]  r_cnt [NUM_PORTS];
  logic [CNT_WIDTH-1:0]  r_total;
  logic [CNT_WIDTH-1:0]  w_rd_sel;
  logic [CNT_WIDTH-1:0]  r_rd_data;
  logic                  r_rd_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RESET;
      r_idle  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idle  <= (w_next == ST_IDLE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET:  w_next = ST_INIT;
      ST_INIT:   if (!init) w_next = ST_IDLE;
      ST_IDLE:   if (Enable && !(&empty_azules)) w_next = ST_ACTIVE;
      ST_ACTIVE: if ((&empty_azules) && !(|w_grant) && !r_v1 && !r_v2)
                   w_next = ST_IDLE;
      default:   w_next = ST_RESET;
    endcase
    if (init && (r_state != ST_RESET)) w_next = ST_INIT;
  end

  assign w_pop_en = (r_state == ST_ACTIVE) && Enable && !almost_full_out;

  arbitro_rr4 u_arbitro (
    .clk   (clk),
    .reset (reset),
    .clear (r_state == ST_INIT),
    .en    (w_pop_en),
    .req   (~empty_azules),
    .grant (w_grant)
  );

  always_comb begin
    w_grant_idx = 2'd0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_grant[p]) w_grant_idx = 2'(p);
    end
  end

  always_comb begin
    w_data_sel = data_in_p0;
    case (r_tag1)
      2'd1:    w_data_sel = data_in_p1;
      2'd2:    w_data_sel = data_in_p2;
      2'd3:    w_data_sel = data_in_p3;
      default: w_data_sel = data_in_p0;
    endcase
  end

  // Stage 1 remembers which FIFO was popped; stage 2 captures its read data
  // one cycle later. Init does not flush these so in-flight words complete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_tag1 <= 2'd0;
      r_v2   <= 1'b0;
      r_tag2 <= 2'd0;
      r_data <= '0;
    end else begin
      r_v1 <= |w_grant;
      if (|w_grant) r_tag1 <= w_grant_idx;
      r_v2 <= r_v1;
      if (r_v1) begin
        r_tag2 <= r_tag1;
        r_data <= w_data_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) r_cnt[p] <= '0;
      r_total <= '0;
    end else if (r_state == ST_INIT) begin
      for (int p = 0; p < NUM_PORTS; p++) r_cnt[p] <= '0;
      r_total <= '0;
    end else if (r_v2) begin
      r_cnt[r_tag2] <= r_cnt[r_tag2] + 1'b1;
      r_total       <= r_total + 1'b1;
    end
  end

  always_comb begin
    w_rd_sel = '0;
    if (!idx[2])               w_rd_sel = r_cnt[idx[1:0]];
    else if (idx == IDX_TOTAL) w_rd_sel = r_total;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= req;
      if (req) r_rd_data <= w_rd_sel;
    end
  end

  assign pop_fifo_azules = w_grant;
  assign data_out        = r_data;
  assign valid_out       = r_v2;
  assign salida_contador = r_rd_data;
  assign valid_contador  = r_rd_valid;
  assign idle            = r_idle;

endmodule

`default_nettype wire

// File: tb/tb_lector_fifos_azules.sv
// ============================================================================
// Module   : tb_lector_fifos_azules
// Brief    : Directed bench for the blue-FIFO merger with a queue-based FIFO
//            model feeding the read ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lector_fifos_azules;

  logic        clk = 1'b0;
  logic        reset, Enable, init, almost_full_out, req;
  logic [11:0] data_in_p0 = '0, data_in_p1 = '0, data_in_p2 = '0, data_in_p3 = '0;
  logic [3:0]  empty_azules = 4'hF;
  logic [2:0]  idx;
  logic [3:0]  pop_fifo_azules;
  logic [11:0] data_out;
  logic        valid_out;
  logic [4:0]  salida_contador;
  logic        valid_contador;
  logic        idle;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [11:0] q0[$], q1[$], q2[$], q3[$];
  logic [11:0] pend0[$], pend1[$], pend2[$], pend3[$];
  logic [3:0]  pop_seen = '0;
  int          grant_log[$], grant_cyc[$], out_cyc[$];
  logic [11:0] out_log[$];

  lector_fifos_azules dut (
    .clk             (clk),
    .reset           (reset),
    .Enable          (Enable),
    .init            (init),
    .data_in_p0      (data_in_p0),
    .data_in_p1      (data_in_p1),
    .data_in_p2      (data_in_p2),
    .data_in_p3      (data_in_p3),
    .empty_azules    (empty_azules),
    .almost_full_out (almost_full_out),
    .req             (req),
    .idx             (idx),
    .pop_fifo_azules (pop_fifo_azules),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .salida_contador (salida_contador),
    .valid_contador  (valid_contador),
    .idle            (idle)
  );

  initial forever #5 clk = ~clk;

  // FIFO model: writes land one cycle after being queued, pops are applied
  // just after the edge that consumed them, and the monitor samples late.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pop_seen[0] && q0.size() > 0) data_in_p0 = q0.pop_front();
      if (pop_seen[1] && q1.size() > 0) data_in_p1 = q1.pop_front();
      if (pop_seen[2] && q2.size() > 0) data_in_p2 = q2.pop_front();
      if (pop_seen[3] && q3.size() > 0) data_in_p3 = q3.pop_front();
      while (pend0.size() > 0) q0.push_back(pend0.pop_front());
      while (pend1.size() > 0) q1.push_back(pend1.pop_front());
      while (pend2.size() > 0) q2.push_back(pend2.pop_front());
      while (pend3.size() > 0) q3.push_back(pend3.pop_front());
      empty_azules = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
      #7;
      pop_seen = pop_fifo_azules;
      for (int p = 0; p < 4; p++) begin
        if (pop_fifo_azules[p]) begin
          grant_log.push_back(p);
          grant_cyc.push_back(cyc);
        end
      end
      if (valid_out) begin
        out_log.push_back(data_out);
        out_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int p, input logic [11:0] v);
    case (p)
      0: pend0.push_back(v);
      1: pend1.push_back(v);
      2: pend2.push_back(v);
      default: pend3.push_back(v);
    endcase
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
    out_log.delete();
    out_cyc.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (3) tick();
    while (idle !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (idle !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_idle: idle=%b after %0d cycles, want 1", idle, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Enable = 1'b0; init = 1'b0; almost_full_out = 1'b0;
    req = 1'b0; idx = 3'd0;
    repeat (3) begin
      tick();
      vectors++;
      if ({pop_fifo_azules, valid_out, data_out, salida_contador, valid_contador, idle} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: pop=%b v=%b d=%h cnt=%h vc=%b idle=%b, want all 0",
                 pop_fifo_azules, valid_out, data_out, salida_contador, valid_contador, idle);
      end
    end
    reset = 1'b0;
    init  = 1'b1;
    tick();
    vectors++;
    if (idle !== 1'b0) begin
      miscompares++; $display("FAIL init_idle_1: idle=%b want 0", idle);
    end
    tick();
    init = 1'b0;
    vectors++;
    if (idle !== 1'b0) begin
      miscompares++; $display("FAIL init_idle_2: idle=%b want 0", idle);
    end
    tick();
    vectors++;
    if (idle !== 1'b1) begin
      miscompares++; $display("FAIL init_release_idle: idle=%b want 1", idle);
    end
    vectors++;
    if (grant_log.size() != 0) begin
      miscompares++; $display("FAIL init_no_pop: pops=%0d want 0", grant_log.size());
    end
  endtask

  task automatic test_single_port();
    logic [11:0] exp [3];
    exp[0] = 12'hA01; exp[1] = 12'hA02; exp[2] = 12'hA03;
    clear_logs();
    Enable = 1'b1;
    for (int k = 0; k < 3; k++) push(2, exp[k]);
    wait_idle(20);
    vectors++;
    if (grant_log.size() != 3 || out_log.size() != 3) begin
      miscompares++;
      $display("FAIL single_counts: pops=%0d outs=%0d want 3/3", grant_log.size(), out_log.size());
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (k >= grant_log.size() || k >= out_log.size()) begin
        miscompares++; $display("FAIL single_word%0d: missing, want %h", k, exp[k]);
      end else if (grant_log[k] != 2 || grant_cyc[k] != grant_cyc[0] + k ||
                   out_log[k] !== exp[k] || out_cyc[k] != grant_cyc[k] + 2) begin
        miscompares++;
        $display("FAIL single_word%0d: port=%0d pcyc=%0d data=%h ocyc=%0d, want port 2 pcyc %0d data %h ocyc %0d",
                 k, grant_log[k], grant_cyc[k], out_log[k], out_cyc[k],
                 grant_cyc[0] + k, exp[k], grant_cyc[0] + k + 2);
      end
    end
    vectors++;
    if (valid_out !== 1'b0 || data_out !== 12'hA03) begin
      miscompares++;
      $display("FAIL single_hold: v=%b d=%h want 0/a03", valid_out, data_out);
    end
  endtask

  task automatic test_round_robin();
    logic [11:0] e;
    init = 1'b1;
    tick();
    init = 1'b0;
    wait_idle(10);
    clear_logs();
    for (int w = 0; w < 2; w++)
      for (int p = 0; p < 4; p++) push(p, 12'hC00 | 12'(p << 4) | 12'(w));
    wait_idle(40);
    vectors++;
    if (grant_log.size() != 8 || out_log.size() != 8) begin
      miscompares++;
      $display("FAIL rr_counts: pops=%0d outs=%0d want 8/8", grant_log.size(), out_log.size());
    end
    for (int k = 0; k < 8; k++) begin
      e = 12'hC00 | 12'((k % 4) << 4) | 12'(k / 4);
      vectors++;
      if (k >= grant_log.size() || k >= out_log.size()) begin
        miscompares++; $display("FAIL rr_word%0d: missing, want %h", k, e);
      end else if (grant_log[k] != k % 4 || grant_cyc[k] != grant_cyc[0] + k ||
                   out_log[k] !== e || out_cyc[k] != grant_cyc[0] + 2 + k) begin
        miscompares++;
        $display("FAIL rr_word%0d: port=%0d pcyc=%0d data=%h ocyc=%0d, want port %0d pcyc %0d data %h ocyc %0d",
                 k, grant_log[k], grant_cyc[k], out_log[k], out_cyc[k],
                 k % 4, grant_cyc[0] + k, e, grant_cyc[0] + 2 + k);
      end
    end
  endtask

  task automatic test_backpressure();
    int af_on, af_off, n_before, n_blocked, n_late, n_drain;
    logic [11:0] e;
    clear_logs();
    for (int w = 0; w < 3; w++)
      for (int p = 0; p < 4; p++) push(p, 12'hD00 | 12'(p << 4) | 12'(w));
    repeat (4) tick();
    af_on = cyc;
    almost_full_out = 1'b1;
    repeat (4) tick();
    af_off = cyc;
    almost_full_out = 1'b0;
    wait_idle(40);
    n_before = 0; n_blocked = 0; n_late = 0; n_drain = 0;
    foreach (grant_cyc[k]) begin
      if (grant_cyc[k] < af_on) n_before++;
      else if (grant_cyc[k] < af_off) n_blocked++;
    end
    foreach (out_cyc[k]) begin
      if (out_cyc[k] >= af_on && out_cyc[k] < af_off + 2) n_drain++;
      if (out_cyc[k] > af_on + 1 && out_cyc[k] < af_off + 2) n_late++;
    end
    vectors++;
    if (n_before != 2 || n_blocked != 0) begin
      miscompares++;
      $display("FAIL bp_pops: before=%0d during=%0d want 2/0", n_before, n_blocked);
    end
    vectors++;
    if (n_drain != 2 || n_late != 0) begin
      miscompares++;
      $display("FAIL bp_drain: drained=%0d late=%0d want 2/0", n_drain, n_late);
    end
    vectors++;
    if (grant_cyc.size() < 3 || grant_cyc[2] != af_off) begin
      miscompares++;
      $display("FAIL bp_resume: pops=%0d resume_cyc=%0d want cyc %0d",
               grant_cyc.size(), (grant_cyc.size() > 2) ? grant_cyc[2] : -1, af_off);
    end
    vectors++;
    if (grant_log.size() != 12 || out_log.size() != 12) begin
      miscompares++;
      $display("FAIL bp_counts: pops=%0d outs=%0d want 12/12", grant_log.size(), out_log.size());
    end
    for (int k = 0; k < 12; k++) begin
      e = 12'hD00 | 12'((k % 4) << 4) | 12'(k / 4);
      vectors++;
      if (k >= grant_log.size() || k >= out_log.size()) begin
        miscompares++; $display("FAIL bp_word%0d: missing, want %h", k, e);
      end else if (grant_log[k] != k % 4 || out_log[k] !== e) begin
        miscompares++;
        $display("FAIL bp_word%0d: port=%0d data=%h want port %0d data %h",
                 k, grant_log[k], out_log[k], k % 4, e);
      end
    end
  endtask

  task automatic test_counters();
    logic [2:0] sel [4];
    logic [4:0] exp [4];
    // p0 saw 2 words in the round-robin run and 3 under backpressure.
    req = 1'b1; idx = 3'd0;
    tick();
    vectors++;
    if (valid_contador !== 1'b1 || salida_contador !== 5'd5) begin
      miscompares++;
      $display("FAIL cnt_p0_pre: vc=%b cnt=%0d want 1/5", valid_contador, salida_contador);
    end
    idx = 3'd4;
    tick();
    vectors++;
    if (valid_contador !== 1'b1 || salida_contador !== 5'd20) begin
      miscompares++;
      $display("FAIL cnt_total_pre: vc=%b cnt=%0d want 1/20", valid_contador, salida_contador);
    end
    req = 1'b0;
    init = 1'b1;
    tick();
    init = 1'b0;
    wait_idle(10);
    clear_logs();
    for (int w = 0; w < 33; w++) push(1, 12'h100 + 12'(w));
    wait_idle(100);
    vectors++;
    if (out_log.size() != 33) begin
      miscompares++; $display("FAIL cnt_stream: outs=%0d want 33", out_log.size());
    end
    sel[0] = 3'd1; exp[0] = 5'd1;
    sel[1] = 3'd6; exp[1] = 5'd0;
    sel[2] = 3'd4; exp[2] = 5'd1;
    sel[3] = 3'd0; exp[3] = 5'd0;
    for (int k = 0; k < 4; k++) begin
      req = 1'b1; idx = sel[k];
      tick();
      vectors++;
      if (valid_contador !== 1'b1 || salida_contador !== exp[k]) begin
        miscompares++;
        $display("FAIL cnt_read_idx%0d: vc=%b cnt=%0d want 1/%0d",
                 sel[k], valid_contador, salida_contador, exp[k]);
      end
    end
    req = 1'b1; idx = 3'd1;
    tick();
    req = 1'b0; idx = 3'd4;
    tick();
    vectors++;
    if (valid_contador !== 1'b0 || salida_contador !== 5'd1) begin
      miscompares++;
      $display("FAIL cnt_hold: vc=%b cnt=%0d want 0/1", valid_contador, salida_contador);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    for (int w = 0; w < 4; w++) push(3, 12'hE00 + 12'(w));
    repeat (4) tick();
    vectors++;
    if (valid_out !== 1'b1 || pop_fifo_azules !== 4'b1000) begin
      miscompares++;
      $display("FAIL mid_pre: v=%b pop=%b want 1/1000", valid_out, pop_fifo_azules);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (valid_out !== 1'b0 || pop_fifo_azules !== 4'b0000 || data_out !== 12'h000 ||
        salida_contador !== 5'd0 || idle !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_async: v=%b pop=%b d=%h cnt=%0d idle=%b want all 0",
               valid_out, pop_fifo_azules, data_out, salida_contador, idle);
    end
    tick();
    reset = 1'b0;
    Enable = 1'b0;
    clear_logs();
    repeat (6) tick();
    vectors++;
    if (out_log.size() != 0 || idle !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_stale: outs=%0d idle=%b want 0/1", out_log.size(), idle);
    end
    req = 1'b1; idx = 3'd4;
    tick();
    req = 1'b0;
    vectors++;
    if (valid_contador !== 1'b1 || salida_contador !== 5'd0) begin
      miscompares++;
      $display("FAIL mid_cnt_clear: vc=%b cnt=%0d want 1/0", valid_contador, salida_contador);
    end
    Enable = 1'b1;
    wait_idle(20);
    vectors++;
    if (out_log.size() != 2 || out_log[0] !== 12'hE02 || out_log[1] !== 12'hE03) begin
      miscompares++;
      $display("FAIL mid_reread: outs=%0d first=%h second=%h want 2/e02/e03", out_log.size(),
               (out_log.size() > 0) ? out_log[0] : 12'h0, (out_log.size() > 1) ? out_log[1] : 12'h0);
    end
    req = 1'b1; idx = 3'd3;
    tick();
    req = 1'b0;
    vectors++;
    if (valid_contador !== 1'b1 || salida_contador !== 5'd2) begin
      miscompares++;
      $display("FAIL mid_cnt_after: vc=%b cnt=%0d want 1/2", valid_contador, salida_contador);
    end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_counters();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
